// File: rtl/monaco_pkg.sv
// Shared definitions for the Monaco-style racer: key codes, sprite geometry,
// motion states and the keycode decoder used by the kinematics stage.
package monaco_pkg;

  localparam logic [7:0] KEY_START = 8'h15;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_ACCEL = 8'h1A;
  localparam logic [7:0] KEY_BRAKE = 8'h16;

  localparam int CAR_W = 40;
  localparam int CAR_H = 78;

  typedef enum logic [1:0] {IDLE, RUN, CRASH} motion_state_t;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_START, CMD_LEFT, CMD_RIGHT, CMD_ACCEL, CMD_BRAKE
  } key_cmd_t;

  function automatic key_cmd_t decode_key(input logic [7:0] code);
    case (code)
      KEY_START: return CMD_START;
      KEY_LEFT:  return CMD_LEFT;
      KEY_RIGHT: return CMD_RIGHT;
      KEY_ACCEL: return CMD_ACCEL;
      KEY_BRAKE: return CMD_BRAKE;
      default:   return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/car_motion_frame_tick_gen.sv
// Brings the asynchronous vertical-sync input into the clk domain and emits a
// single-cycle pulse per rising edge (registered, three edges after the rise).
module frame_tick_gen (
  input  logic clk,
  input  logic srst,
  input  logic frame_clk,
  output logic frame_tick
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       tick_q, tick_d;

  always_comb begin
    sync_d = {sync_q[0], frame_clk};
    prev_d = sync_q[1];
    tick_d = sync_q[1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      tick_q <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/car_motion.sv
// Player-car kinematics: start gate, speed ramp, clamped steering, road scroll
// and crash/respawn, all advanced once per video frame.
module car_motion
  import monaco_pkg::*;
#(
  parameter int CAR_X_INIT   = 300,
  parameter int CAR_Y_INIT   = 380,
  parameter int ROAD_L       = 160,
  parameter int ROAD_R       = 480,
  parameter int STEP_X       = 2,
  parameter int MAX_SPEED    = 7,
  parameter int ACCEL_FRAMES = 8,
  parameter int CRASH_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       collision,
  output logic [9:0] CarX,
  output logic [9:0] CarY,
  output logic [2:0] speed,
  output logic [9:0] road_offset,
  output logic       running,
  output logic       crashed
);

  localparam int ACW = $clog2(ACCEL_FRAMES);
  localparam int CCW = $clog2(CRASH_FRAMES);
  localparam logic [9:0] X_MIN  = 10'(ROAD_L);
  localparam logic [9:0] X_MAX  = 10'(ROAD_R - CAR_W);
  localparam logic [9:0] X_INIT = 10'(CAR_X_INIT);

  motion_state_t  state_q, state_d;
  key_cmd_t       cmd;
  logic           frame_tick;

  logic [9:0]     car_x_q, car_x_d;
  logic [2:0]     speed_q, speed_d;
  logic [9:0]     road_q, road_d;
  logic [ACW-1:0] accel_cnt_q, accel_cnt_d;
  logic [CCW-1:0] crash_cnt_q, crash_cnt_d;
  logic           running_q, running_d;
  logic           crashed_q, crashed_d;

  logic [10:0]    x_ext, x_plus;
  logic           x_at_left, x_at_right;

  frame_tick_gen u_tick (
    .clk        (Clk),
    .srst       (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  assign cmd = decode_key(keycode);

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (cmd == CMD_START) state_d = RUN;
      RUN:   if (frame_tick && collision) state_d = CRASH;
      CRASH: if (frame_tick && crash_cnt_q == CCW'(CRASH_FRAMES - 1)) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Edge tests run in 11 bits so a step past either road edge cannot wrap.
  always_comb begin
    x_ext      = {1'b0, car_x_q};
    x_plus     = x_ext + 11'(STEP_X);
    x_at_left  = x_ext < 11'(ROAD_L + STEP_X);
    x_at_right = x_plus > 11'(ROAD_R - CAR_W);
  end

  always_comb begin
    car_x_d     = car_x_q;
    speed_d     = speed_q;
    road_d      = road_q;
    accel_cnt_d = accel_cnt_q;
    crash_cnt_d = crash_cnt_q;
    running_d   = running_q;
    crashed_d   = crashed_q;
    case (state_q)
      IDLE: begin
        if (cmd == CMD_START) running_d = 1'b1;
      end
      RUN: begin
        if (frame_tick) begin
          if (collision) begin
            speed_d     = 3'd0;
            crash_cnt_d = '0;
            accel_cnt_d = '0;
            crashed_d   = 1'b1;
          end else begin
            case (cmd)
              CMD_ACCEL: begin
                if (accel_cnt_q == ACW'(ACCEL_FRAMES - 1)) begin
                  accel_cnt_d = '0;
                  if (speed_q != 3'(MAX_SPEED)) speed_d = speed_q + 3'd1;
                end else begin
                  accel_cnt_d = accel_cnt_q + ACW'(1);
                end
              end
              CMD_BRAKE: begin
                accel_cnt_d = '0;
                if (speed_q != 3'd0) speed_d = speed_q - 3'd1;
              end
              default: accel_cnt_d = '0;
            endcase
            // Steering and scroll both use the speed held before this frame.
            if (speed_q != 3'd0) begin
              if (cmd == CMD_LEFT)
                car_x_d = x_at_left ? X_MIN : car_x_q - 10'(STEP_X);
              else if (cmd == CMD_RIGHT)
                car_x_d = x_at_right ? X_MAX : car_x_q + 10'(STEP_X);
            end
            road_d = road_q + {7'd0, speed_q};
          end
        end
      end
      CRASH: begin
        if (frame_tick) begin
          if (crash_cnt_q == CCW'(CRASH_FRAMES - 1)) begin
            car_x_d     = X_INIT;
            crashed_d   = 1'b0;
            speed_d     = 3'd0;
            crash_cnt_d = '0;
            accel_cnt_d = '0;
          end else begin
            crash_cnt_d = crash_cnt_q + CCW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      car_x_q     <= X_INIT;
      speed_q     <= 3'd0;
      road_q      <= 10'd0;
      accel_cnt_q <= '0;
      crash_cnt_q <= '0;
      running_q   <= 1'b0;
      crashed_q   <= 1'b0;
    end else begin
      car_x_q     <= car_x_d;
      speed_q     <= speed_d;
      road_q      <= road_d;
      accel_cnt_q <= accel_cnt_d;
      crash_cnt_q <= crash_cnt_d;
      running_q   <= running_d;
      crashed_q   <= crashed_d;
    end
  end

  assign CarX        = car_x_q;
  assign CarY        = 10'(CAR_Y_INIT);
  assign speed       = speed_q;
  assign road_offset = road_q;
  assign running     = running_q;
  assign crashed     = crashed_q;

endmodule

// File: tb/tb_car_motion.sv
// Scenario bench for car_motion: directed sequences plus a random phase, all
// scored against a frame-level behavioural model of the car.
module tb_car_motion;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       collision;
  logic [9:0] CarX, CarY, road_offset;
  logic [2:0] speed;
  logic       running, crashed;

  int compared   = 0;
  int mismatched = 0;

  // Model: 0 idle, 1 run, 2 crash
  int m_state, m_x, m_spd, m_road, m_run, m_crashed, m_accel_run, m_crash_ticks;

  logic [7:0] key_tbl [8] = '{8'h00, 8'h15, 8'h04, 8'h07, 8'h1A, 8'h16, 8'h33, 8'hFF};

  car_motion dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .collision   (collision),
    .CarX        (CarX),
    .CarY        (CarY),
    .speed       (speed),
    .road_offset (road_offset),
    .running     (running),
    .crashed     (crashed)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_state = 0; m_x = 300; m_spd = 0; m_road = 0; m_run = 0; m_crashed = 0;
    m_accel_run = 0; m_crash_ticks = 0;
  endtask

  task automatic model_tick(input logic [7:0] k, input logic c);
    int pre;
    if (m_state == 1) begin
      if (c) begin
        m_state = 2; m_spd = 0; m_crashed = 1; m_crash_ticks = 0; m_accel_run = 0;
      end else begin
        pre = m_spd;
        if (k == 8'h1A) begin
          m_accel_run++;
          if (m_accel_run % 8 == 0 && m_spd < 7) m_spd++;
        end else begin
          m_accel_run = 0;
          if (k == 8'h16 && m_spd > 0) m_spd--;
        end
        if (pre != 0) begin
          if (k == 8'h04) m_x = (m_x - 2 < 160) ? 160 : m_x - 2;
          else if (k == 8'h07) m_x = (m_x + 2 > 440) ? 440 : m_x + 2;
        end
        m_road = (m_road + pre) % 1024;
      end
    end else if (m_state == 2) begin
      m_crash_ticks++;
      if (m_crash_ticks == 60) begin
        m_state = 1; m_x = 300; m_crashed = 0; m_spd = 0; m_accel_run = 0;
      end
    end
  endtask

  // One video frame: key/collision applied, one frame_clk pulse, model advanced.
  task automatic do_frame(input logic [7:0] k, input logic c);
    @(negedge Clk);
    keycode = k; collision = c;
    @(negedge Clk); @(negedge Clk);
    if (m_state == 0 && k == 8'h15) begin m_state = 1; m_run = 1; end
    frame_clk = 1'b1;
    repeat (6) @(negedge Clk);
    frame_clk = 1'b0; collision = 1'b0;
    repeat (3) @(negedge Clk);
    model_tick(k, c);
  endtask

  task automatic test_reset();
    Reset = 1'b1; keycode = 8'h00; frame_clk = 1'b0; collision = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
    compared += 6;
    if (CarX !== 10'd300) begin mismatched++; $display("FAIL reset_carx got %0d want 300", CarX); end
    if (CarY !== 10'd380) begin mismatched++; $display("FAIL reset_cary got %0d want 380", CarY); end
    if (speed !== 3'd0) begin mismatched++; $display("FAIL reset_speed got %0d want 0", speed); end
    if (road_offset !== 10'd0) begin mismatched++; $display("FAIL reset_road got %0d want 0", road_offset); end
    if (running !== 1'b0) begin mismatched++; $display("FAIL reset_running got %0b want 0", running); end
    if (crashed !== 1'b0) begin mismatched++; $display("FAIL reset_crashed got %0b want 0", crashed); end
  endtask

  task automatic test_idle_start();
    for (int f = 0; f < 5; f++) do_frame(8'h1A, 1'b0);
    compared += 4;
    if (CarX !== 10'd300) begin mismatched++; $display("FAIL idle_carx got %0d want 300", CarX); end
    if (speed !== 3'd0) begin mismatched++; $display("FAIL idle_speed got %0d want 0", speed); end
    if (running !== 1'b0) begin mismatched++; $display("FAIL idle_running got %0b want 0", running); end
    if (road_offset !== 10'd0) begin mismatched++; $display("FAIL idle_road got %0d want 0", road_offset); end
    @(negedge Clk);
    keycode = 8'h15;
    @(posedge Clk); #1;
    compared++;
    if (running !== 1'b1) begin mismatched++; $display("FAIL start_running got %0b want 1", running); end
    m_state = 1; m_run = 1;
  endtask

  task automatic test_accel();
    for (int f = 1; f <= 64; f++) begin
      do_frame(8'h1A, 1'b0);
      compared += 3;
      if (speed !== 3'(m_spd)) begin mismatched++; $display("FAIL accel_speed frame %0d got %0d want %0d", f, speed, m_spd); end
      if (road_offset !== 10'(m_road)) begin mismatched++; $display("FAIL accel_road frame %0d got %0d want %0d", f, road_offset, m_road); end
      if (CarX !== 10'(m_x)) begin mismatched++; $display("FAIL accel_carx frame %0d got %0d want %0d", f, CarX, m_x); end
      if (f == 8 || f == 55 || f == 56) begin
        compared++;
        if (speed !== ((f == 8) ? 3'd1 : (f == 55) ? 3'd6 : 3'd7)) begin
          mismatched++; $display("FAIL accel_step frame %0d got %0d", f, speed);
        end
      end
    end
    // Cruise at top speed long enough for the scroll counter to wrap.
    for (int f = 1; f <= 120; f++) begin
      do_frame(key_tbl[6 + (f % 2)], 1'b0);
      compared += 2;
      if (road_offset !== 10'(m_road)) begin mismatched++; $display("FAIL wrap_road frame %0d got %0d want %0d", f, road_offset, m_road); end
      if (speed !== 3'd7) begin mismatched++; $display("FAIL cruise_speed frame %0d got %0d want 7", f, speed); end
    end
  endtask

  task automatic test_steer_clamp();
    int exp_l [4] = '{162, 160, 160, 160};
    int exp_r [2] = '{440, 440};
    for (int f = 0; f < 4; f++) do_frame(8'h16, 1'b0);
    compared++;
    if (speed !== 3'd3) begin mismatched++; $display("FAIL brake_to3 got %0d want 3", speed); end
    for (int i = 0; i < 100 && m_x > 164; i++) do_frame(8'h04, 1'b0);
    compared++;
    if (CarX !== 10'd164) begin mismatched++; $display("FAIL steer_to164 got %0d want 164", CarX); end
    for (int f = 0; f < 4; f++) begin
      do_frame(8'h04, 1'b0);
      compared++;
      if (CarX !== 10'(exp_l[f])) begin mismatched++; $display("FAIL left_clamp step %0d got %0d want %0d", f, CarX, exp_l[f]); end
    end
    for (int i = 0; i < 200 && m_x < 438; i++) do_frame(8'h07, 1'b0);
    compared++;
    if (CarX !== 10'd438) begin mismatched++; $display("FAIL steer_to438 got %0d want 438", CarX); end
    for (int f = 0; f < 2; f++) begin
      do_frame(8'h07, 1'b0);
      compared++;
      if (CarX !== 10'(exp_r[f])) begin mismatched++; $display("FAIL right_clamp step %0d got %0d want %0d", f, CarX, exp_r[f]); end
    end
  endtask

  task automatic test_zero_speed();
    for (int f = 0; f < 3; f++) do_frame(8'h16, 1'b0);
    compared++;
    if (speed !== 3'd0) begin mismatched++; $display("FAIL brake_to0 got %0d want 0", speed); end
    for (int f = 0; f < 10; f++) begin
      do_frame(8'h07, 1'b0);
      compared += 2;
      if (CarX !== 10'd440) begin mismatched++; $display("FAIL stopped_carx frame %0d got %0d want 440", f, CarX); end
      if (road_offset !== 10'(m_road)) begin mismatched++; $display("FAIL stopped_road frame %0d got %0d want %0d", f, road_offset, m_road); end
    end
    do_frame(8'h16, 1'b0);
    compared++;
    if (speed !== 3'd0) begin mismatched++; $display("FAIL brake_at0 got %0d want 0", speed); end
  endtask

  task automatic test_crash();
    int x0, r0;
    for (int f = 0; f < 40; f++) do_frame(8'h1A, 1'b0);
    compared++;
    if (speed !== 3'd5) begin mismatched++; $display("FAIL pre_crash_speed got %0d want 5", speed); end
    x0 = m_x; r0 = m_road;
    do_frame(8'h1A, 1'b1);
    compared += 4;
    if (crashed !== 1'b1) begin mismatched++; $display("FAIL crash_flag got %0b want 1", crashed); end
    if (speed !== 3'd0) begin mismatched++; $display("FAIL crash_speed got %0d want 0", speed); end
    if (CarX !== 10'(x0)) begin mismatched++; $display("FAIL crash_carx got %0d want %0d", CarX, x0); end
    if (road_offset !== 10'(r0)) begin mismatched++; $display("FAIL crash_road got %0d want %0d", road_offset, r0); end
    for (int t = 1; t <= 60; t++) begin
      do_frame(key_tbl[$urandom_range(0, 7)], 1'($urandom_range(0, 1)));
      compared += 4;
      if (t < 60) begin
        if (crashed !== 1'b1) begin mismatched++; $display("FAIL frozen_flag tick %0d got %0b want 1", t, crashed); end
        if (CarX !== 10'(x0)) begin mismatched++; $display("FAIL frozen_carx tick %0d got %0d want %0d", t, CarX, x0); end
      end else begin
        if (crashed !== 1'b0) begin mismatched++; $display("FAIL respawn_flag got %0b want 0", crashed); end
        if (CarX !== 10'd300) begin mismatched++; $display("FAIL respawn_carx got %0d want 300", CarX); end
      end
      if (road_offset !== 10'(r0)) begin mismatched++; $display("FAIL frozen_road tick %0d got %0d want %0d", t, road_offset, r0); end
      if (speed !== 3'd0) begin mismatched++; $display("FAIL frozen_speed tick %0d got %0d want 0", t, speed); end
    end
    for (int f = 1; f <= 8; f++) begin
      do_frame(8'h1A, 1'b0);
      compared++;
      if (speed !== ((f == 8) ? 3'd1 : 3'd0)) begin mismatched++; $display("FAIL resume_accel frame %0d got %0d", f, speed); end
    end
  endtask

  task automatic test_random();
    logic [7:0] k;
    logic       c;
    for (int f = 0; f < 200; f++) begin
      k = key_tbl[$urandom_range(0, 7)];
      c = ($urandom_range(0, 15) == 0);
      do_frame(k, c);
      compared += 5;
      if (CarX !== 10'(m_x)) begin mismatched++; $display("FAIL rand_carx frame %0d key %h got %0d want %0d", f, k, CarX, m_x); end
      if (speed !== 3'(m_spd)) begin mismatched++; $display("FAIL rand_speed frame %0d key %h got %0d want %0d", f, k, speed, m_spd); end
      if (road_offset !== 10'(m_road)) begin mismatched++; $display("FAIL rand_road frame %0d got %0d want %0d", f, road_offset, m_road); end
      if (crashed !== 1'(m_crashed)) begin mismatched++; $display("FAIL rand_crashed frame %0d got %0b want %0d", f, crashed, m_crashed); end
      if (running !== 1'(m_run)) begin mismatched++; $display("FAIL rand_running frame %0d got %0b want %0d", f, running, m_run); end
    end
  endtask

  task automatic test_reset_mid_crash();
    for (int i = 0; i < 100 && !(m_state == 2 && m_crash_ticks < 50); i++) do_frame(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) do_frame(8'h1A, 1'b0);
    compared++;
    if (crashed !== 1'b1) begin mismatched++; $display("FAIL midcrash_setup got %0b want 1", crashed); end
    @(negedge Clk);
    keycode = 8'h1A;
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    compared += 5;
    if (CarX !== 10'd300) begin mismatched++; $display("FAIL rst_mid_carx got %0d want 300", CarX); end
    if (speed !== 3'd0) begin mismatched++; $display("FAIL rst_mid_speed got %0d want 0", speed); end
    if (road_offset !== 10'd0) begin mismatched++; $display("FAIL rst_mid_road got %0d want 0", road_offset); end
    if (running !== 1'b0) begin mismatched++; $display("FAIL rst_mid_running got %0b want 0", running); end
    if (crashed !== 1'b0) begin mismatched++; $display("FAIL rst_mid_crashed got %0b want 0", crashed); end
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    repeat (6) @(negedge Clk);
    for (int f = 0; f < 3; f++) begin
      do_frame(8'h1A, 1'b0);
      compared += 3;
      if (running !== 1'b0) begin mismatched++; $display("FAIL post_rst_running frame %0d got %0b want 0", f, running); end
      if (speed !== 3'd0) begin mismatched++; $display("FAIL post_rst_speed frame %0d got %0d want 0", f, speed); end
      if (road_offset !== 10'd0) begin mismatched++; $display("FAIL post_rst_road frame %0d got %0d want 0", f, road_offset); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_start();
    test_accel();
    test_steer_clamp();
    test_zero_speed();
    test_crash();
    test_random();
    test_reset_mid_crash();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
